// File: rtl/pipeline_interlock.sv
// pipeline_interlock: hazard and stall controller for the five-stage F D E M W
// pipeline. Keeps a 2-bit countdown per architectural register for results that
// are not yet forwardable, stalls decode on RAW / load-use hazards, freezes the
// whole pipe during data-cache misses (with a sticky timeout flag) and flushes
// decode on taken branches.
//
// Ports:
//   clk, reset            pipeline clock (rising edge), async active-low reset
//   d_valid               decode holds a real instruction
//   d_rs1/_used, d_rs2/_used, d_rd, d_writes, d_is_load   decode operand info
//   e_branch_taken        branch resolved taken in E this cycle
//   icache_busy           instruction cache servicing a miss
//   dcache_busy           data cache servicing a miss
//   stall                 decode hazard: hold F and D, bubble into E
//   stall_f               hold PC and F/D register
//   bubble_e              write nop into D/E register
//   flush_d               kill F/D contents
//   freeze                hold every pipeline register
//   mem_timeout           sticky: a miss lasted MEM_TIMEOUT cycles
//   pending               bit i set while register i has an in-flight result
//
// state       | meaning
// ST_RUN      | normal operation; a dcache miss starts the wait count
// ST_MEM_WAIT | data-cache miss in progress; wait counter runs
module pipeline_interlock #(
   parameter int NUM_REGS       = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int ALU_READY      = 1,
   parameter int LOAD_READY     = 2,
   parameter int MEM_TIMEOUT    = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      d_valid,
   input  logic [REG_ADDR_WIDTH-1:0] d_rs1,
   input  logic                      d_rs1_used,
   input  logic [REG_ADDR_WIDTH-1:0] d_rs2,
   input  logic                      d_rs2_used,
   input  logic [REG_ADDR_WIDTH-1:0] d_rd,
   input  logic                      d_writes,
   input  logic                      d_is_load,
   input  logic                      e_branch_taken,
   input  logic                      icache_busy,
   input  logic                      dcache_busy,
   output logic                      stall,
   output logic                      stall_f,
   output logic                      bubble_e,
   output logic                      flush_d,
   output logic                      freeze,
   output logic                      mem_timeout,
   output logic [NUM_REGS-1:0]       pending
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [1:0]        ALU_LAT  = 2'(ALU_READY);
   localparam logic [1:0]        LOAD_LAT = 2'(LOAD_READY);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

   typedef enum logic {ST_RUN, ST_MEM_WAIT} state_t;

   state_t              r_state, w_state_nxt;
   logic [WAIT_W-1:0]   r_wait, w_wait_nxt;
   logic                r_timeout, w_timeout_nxt;

   logic [NUM_REGS-1:0] w_pend;
   logic                w_haz;
   logic                w_freeze;
   logic                w_flush;
   logic                w_stall;
   logic                w_issue;

   // Freeze follows the miss directly so it drops in the same cycle the cache
   // releases; the FSM only tracks how long the miss has lasted. Gating with
   // reset keeps every output low while reset is asserted.
   assign w_freeze = reset & dcache_busy;
   assign w_flush  = reset & e_branch_taken & ~w_freeze;
   assign w_haz    = d_valid & ((d_rs1_used & w_pend[d_rs1]) |
                                (d_rs2_used & w_pend[d_rs2]));
   assign w_stall  = w_haz & ~w_freeze & ~w_flush;
   assign w_issue  = d_valid & ~w_haz & ~w_freeze & ~w_flush;

   assign stall       = w_stall;
   assign bubble_e    = w_stall | w_flush;
   assign flush_d     = w_flush;
   assign stall_f     = w_stall | (reset & icache_busy & ~w_flush);
   assign freeze      = w_freeze;
   assign mem_timeout = r_timeout;
   assign pending     = w_pend;

   // Scoreboard: r0 never pends; others load on issue and count down when unfrozen.
   for (genvar g = 0; g < NUM_REGS; g++) begin : g_sb
      if (g == 0) begin : g_zero
         assign w_pend[g] = 1'b0;
      end else begin : g_cnt
         logic [1:0] r_cnt;
         logic       w_load;

         assign w_load    = w_issue & d_writes & (d_rd == REG_ADDR_WIDTH'(g));
         assign w_pend[g] = (r_cnt != 2'd0);

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               r_cnt <= 2'd0;
            end else if (!w_freeze) begin
               if (w_load)
                  r_cnt <= d_is_load ? LOAD_LAT : ALU_LAT;
               else if (r_cnt != 2'd0)
                  r_cnt <= r_cnt - 2'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_RUN;
         r_wait    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_wait    <= w_wait_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_wait_nxt    = r_wait;
      w_timeout_nxt = r_timeout;
      if (r_state == ST_RUN) begin
         if (dcache_busy) begin
            w_state_nxt = ST_MEM_WAIT;
            w_wait_nxt  = WAIT_W'(1);
         end
      end else begin
         if (!dcache_busy) begin
            w_state_nxt = ST_RUN;
            w_wait_nxt  = '0;
         end else if (r_wait != WAIT_MAX) begin
            w_wait_nxt = r_wait + WAIT_W'(1);
         end
      end
      // Registered so the flag is visible in the cycle whose count equals MEM_TIMEOUT.
      if (w_state_nxt == ST_MEM_WAIT && w_wait_nxt == WAIT_MAX)
         w_timeout_nxt = 1'b1;
   end

endmodule

// File: tb/tb_pipeline_interlock.sv
module tb_pipeline_interlock;
   localparam int NR = 32;
   localparam int MT = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        d_valid = 1'b0;
   logic [4:0]  d_rs1 = '0;
   logic        d_rs1_used = 1'b0;
   logic [4:0]  d_rs2 = '0;
   logic        d_rs2_used = 1'b0;
   logic [4:0]  d_rd = '0;
   logic        d_writes = 1'b0;
   logic        d_is_load = 1'b0;
   logic        e_branch_taken = 1'b0;
   logic        icache_busy = 1'b0;
   logic        dcache_busy = 1'b0;
   logic        stall, stall_f, bubble_e, flush_d, freeze, mem_timeout;
   logic [31:0] pending;

   pipeline_interlock dut (
      .clk(clk), .reset(reset),
      .d_valid(d_valid), .d_rs1(d_rs1), .d_rs1_used(d_rs1_used),
      .d_rs2(d_rs2), .d_rs2_used(d_rs2_used), .d_rd(d_rd),
      .d_writes(d_writes), .d_is_load(d_is_load),
      .e_branch_taken(e_branch_taken), .icache_busy(icache_busy),
      .dcache_busy(dcache_busy),
      .stall(stall), .stall_f(stall_f), .bubble_e(bubble_e),
      .flush_d(flush_d), .freeze(freeze), .mem_timeout(mem_timeout),
      .pending(pending)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a result written by an instruction issued in unfrozen
   // cycle u with latency L becomes readable once L+1 unfrozen cycles elapse.
   int ucyc = 0;
   int ready_at [NR];
   int run = 0;
   bit sticky = 0;

   always @(negedge clk) begin
      logic [31:0] pv;
      bit haz, frz, fl, st, sf, bub;
      if (!reset) begin
         ucyc = 0; run = 0; sticky = 0;
         for (int i = 0; i < NR; i++) ready_at[i] = 0;
         check("m_reset_outs", {26'd0, stall, stall_f, bubble_e, flush_d, freeze, mem_timeout}, 32'd0);
         check("m_reset_pending", pending, 32'd0);
      end else begin
         for (int i = 0; i < NR; i++) pv[i] = (i != 0) && (ucyc < ready_at[i]);
         haz = d_valid && ((d_rs1_used && pv[d_rs1]) || (d_rs2_used && pv[d_rs2]));
         frz = dcache_busy;
         fl  = e_branch_taken && !frz;
         st  = haz && !frz && !fl;
         bub = st || fl;
         sf  = st || (icache_busy && !fl);
         check("m_stall", {31'd0, stall}, {31'd0, st});
         check("m_stall_f", {31'd0, stall_f}, {31'd0, sf});
         check("m_bubble_e", {31'd0, bubble_e}, {31'd0, bub});
         check("m_flush_d", {31'd0, flush_d}, {31'd0, fl});
         check("m_freeze", {31'd0, freeze}, {31'd0, frz});
         check("m_mem_timeout", {31'd0, mem_timeout}, {31'd0, sticky});
         check("m_pending", pending, pv);
         if (!frz) begin
            if (d_valid && !haz && !fl && d_writes && d_rd != 0)
               ready_at[d_rd] = ucyc + 1 + (d_is_load ? 2 : 1);
            ucyc++;
         end
         if (dcache_busy) begin
            if (run < MT) run++;
            if (run == MT) sticky = 1;
         end else begin
            run = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      d_valid = 0; d_rs1 = 0; d_rs1_used = 0; d_rs2 = 0; d_rs2_used = 0;
      d_rd = 0; d_writes = 0; d_is_load = 0;
      e_branch_taken = 0; icache_busy = 0; dcache_busy = 0;
   endtask

   task automatic instr(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                        input logic u2, input logic [4:0] rd, input logic w, input logic ld);
      d_valid = 1; d_rs1 = rs1; d_rs1_used = u1; d_rs2 = rs2; d_rs2_used = u2;
      d_rd = rd; d_writes = w; d_is_load = ld;
   endtask

   initial begin
      idle();
      dcache_busy = 1; icache_busy = 1; e_branch_taken = 1;
      instr(5'd1, 1, 5'd1, 1, 5'd2, 1, 0);
      @(negedge clk);
      check("rst_outs", {26'd0, stall, stall_f, bubble_e, flush_d, freeze, mem_timeout}, 32'd0);
      check("rst_pending", pending, 32'd0);
      tick();
      reset = 1; idle();
      @(negedge clk); tick();

      // ALU -> ALU: one stall cycle
      instr(5'd1, 1, 5'd1, 1, 5'd2, 1, 0);
      @(negedge clk); check("alu_issue_stall", {31'd0, stall}, 32'd0); tick();
      instr(5'd2, 1, 5'd2, 1, 5'd3, 1, 0);
      @(negedge clk);
      check("alu_dep_stall", {31'd0, stall}, 32'd1);
      check("alu_dep_bubble", {31'd0, bubble_e}, 32'd1);
      check("alu_dep_pend2", {31'd0, pending[2]}, 32'd1);
      tick();
      @(negedge clk);
      check("alu_dep_release", {31'd0, stall}, 32'd0);
      check("alu_pend2_clear", {31'd0, pending[2]}, 32'd0);
      tick();
      idle(); repeat (3) tick();

      // load-use: two stall cycles
      instr(5'd1, 1, 5'd0, 0, 5'd4, 1, 1);
      @(negedge clk); tick();
      instr(5'd4, 1, 5'd4, 1, 5'd5, 1, 0);
      @(negedge clk); check("lu_stall1", {31'd0, stall}, 32'd1); tick();
      @(negedge clk); check("lu_stall2", {31'd0, stall}, 32'd1); tick();
      @(negedge clk);
      check("lu_release", {31'd0, stall}, 32'd0);
      check("lu_pend4_clear", {31'd0, pending[4]}, 32'd0);
      tick();
      idle(); repeat (3) tick();

      // r0 stream never hazards
      instr(5'd0, 1, 5'd0, 1, 5'd0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("r0_stall", {31'd0, stall}, 32'd0);
         check("r0_pending", pending, 32'd0);
         tick();
      end
      idle(); tick();

      // freeze holds the scoreboard; hazard re-evaluates after release
      instr(5'd1, 1, 5'd1, 1, 5'd2, 1, 0);
      @(negedge clk); tick();
      instr(5'd2, 1, 5'd2, 1, 5'd3, 1, 0);
      dcache_busy = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("frz_freeze", {31'd0, freeze}, 32'd1);
         check("frz_stall", {31'd0, stall}, 32'd0);
         check("frz_pend2", {31'd0, pending[2]}, 32'd1);
         tick();
      end
      dcache_busy = 0;
      @(negedge clk);
      check("frz_release_freeze", {31'd0, freeze}, 32'd0);
      check("frz_release_stall", {31'd0, stall}, 32'd1);
      tick();
      @(negedge clk); check("frz_after_stall", {31'd0, stall}, 32'd0); tick();
      idle(); repeat (3) tick();

      // branch flush beats a hazard; killed instruction not scoreboarded
      instr(5'd1, 1, 5'd1, 1, 5'd6, 1, 0);
      @(negedge clk); tick();
      instr(5'd6, 1, 5'd0, 0, 5'd7, 1, 0);
      e_branch_taken = 1;
      @(negedge clk);
      check("br_flush", {31'd0, flush_d}, 32'd1);
      check("br_bubble", {31'd0, bubble_e}, 32'd1);
      check("br_stall", {31'd0, stall}, 32'd0);
      tick();
      idle();
      @(negedge clk); check("br_pend7", {31'd0, pending[7]}, 32'd0); tick();

      // long miss: timeout on MEM_WAIT cycle 64, sticky afterwards
      dcache_busy = 1;
      @(negedge clk); tick();
      for (int k = 1; k < 70; k++) begin
         @(negedge clk);
         if (k == 63) check("to_before", {31'd0, mem_timeout}, 32'd0);
         if (k == 64) check("to_rise", {31'd0, mem_timeout}, 32'd1);
         tick();
      end
      dcache_busy = 0;
      @(negedge clk);
      check("to_sticky", {31'd0, mem_timeout}, 32'd1);
      check("to_unfreeze", {31'd0, freeze}, 32'd0);
      tick();

      // reset in the middle of a miss
      instr(5'd0, 0, 5'd0, 0, 5'd8, 1, 1);
      @(negedge clk); tick();
      idle(); dcache_busy = 1;
      @(negedge clk); check("mid_pend8", {31'd0, pending[8]}, 32'd1); tick();
      reset = 0;
      #1;
      check("mid_rst_freeze", {31'd0, freeze}, 32'd0);
      check("mid_rst_pending", pending, 32'd0);
      check("mid_rst_timeout", {31'd0, mem_timeout}, 32'd0);
      tick();
      reset = 1; dcache_busy = 0;
      tick();

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         reset = ($urandom_range(0, 499) != 0);
         d_valid    = ($urandom_range(0, 9) < 7);
         d_rs1      = 5'($urandom_range(0, 7));
         d_rs1_used = 1'($urandom_range(0, 1));
         d_rs2      = 5'($urandom_range(0, 7));
         d_rs2_used = 1'($urandom_range(0, 1));
         d_rd       = 5'($urandom_range(0, 7));
         d_writes   = ($urandom_range(0, 9) < 8);
         d_is_load  = ($urandom_range(0, 9) < 3);
         e_branch_taken = ($urandom_range(0, 99) < 8);
         icache_busy    = ($urandom_range(0, 9) == 0);
         if (dcache_busy) dcache_busy = ($urandom_range(0, 9) >= 3);
         else             dcache_busy = ($urandom_range(0, 99) < 5);
         tick();
      end
      idle(); reset = 1;
      repeat (2) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
